// File: rtl/pool_window_buffer.sv
`default_nettype none
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
// +----------------------------------------------------------------------------+
// | Module      : pool_window_buffer                                           |
// | Description : One-line buffer turning a raster pixel stream into stride-2  |
// |               2x2 windows for the max-pool unit. POOL_WIN_RELU_EN clamps   |
// |               negative pixels to zero on entry.                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pool_window_buffer #(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    output logic                         win_valid,
    input  logic                         win_ready,
    output logic signed [DATA_WIDTH-1:0] win_a00,
    output logic signed [DATA_WIDTH-1:0] win_a01,
    output logic signed [DATA_WIDTH-1:0] win_a10,
    output logic signed [DATA_WIDTH-1:0] win_a11,
    output logic                         frame_done
);

    localparam int c_COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int c_ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(IMG_WIDTH - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(IMG_HEIGHT - 1);

    logic        [c_COL_W-1:0]    r_col;
    logic        [c_ROW_W-1:0]    r_row;
    logic signed [DATA_WIDTH-1:0] r_held;
    logic signed [DATA_WIDTH-1:0] r_linebuf [IMG_WIDTH];
    logic                         r_win_valid;
    logic                         r_frame_done;
    logic signed [DATA_WIDTH-1:0] r_a00, r_a01, r_a10, r_a11;

    logic                         w_accept;
    logic                         w_col_last;
    logic                         w_row_last;
    logic                         w_win_load;
    logic signed [DATA_WIDTH-1:0] w_pix;

    assign in_ready   = !r_win_valid || win_ready;
    assign w_accept   = in_valid && in_ready;
    assign w_col_last = (r_col == c_COL_LAST);
    assign w_row_last = (r_row == c_ROW_LAST);
    // Odd row and odd column: this pixel is the bottom-right corner.
    assign w_win_load = w_accept && r_row[0] && r_col[0];

    always_comb begin
        w_pix = in_data;
`ifdef POOL_WIN_RELU_EN
        if (in_data[DATA_WIDTH-1]) begin
            w_pix = '0;
        end
`endif
    end

    // Line buffer is deliberately unreset; every entry is rewritten before use.
    always_ff @(posedge clk) begin
        if (w_accept && !r_row[0]) begin
            r_linebuf[r_col] <= w_pix;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col        <= '0;
            r_row        <= '0;
            r_held       <= '0;
            r_win_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_a00        <= '0;
            r_a01        <= '0;
            r_a10        <= '0;
            r_a11        <= '0;
        end else begin
            r_frame_done <= w_accept && w_col_last && w_row_last;
            if (w_accept) begin
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
                if (r_row[0] && !r_col[0]) begin
                    r_held <= w_pix;
                end
            end
            if (w_win_load) begin
                r_a00       <= r_linebuf[r_col - 1'b1];
                r_a01       <= r_linebuf[r_col];
                r_a10       <= r_held;
                r_a11       <= w_pix;
                r_win_valid <= 1'b1;
            end else if (win_ready) begin
                r_win_valid <= 1'b0;
            end
        end
    end

    assign win_valid  = r_win_valid;
    assign frame_done = r_frame_done;
    assign win_a00    = r_a00;
    assign win_a01    = r_a01;
    assign win_a10    = r_a10;
    assign win_a11    = r_a11;

endmodule
`default_nettype wire

// File: tb/tb_pool_window_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pool_window_buffer                                        |
// | Description : Directed and randomized checks of pool_window_buffer on      |
// |               4x4, 5x3 and 6x4 frame geometries.                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pool_window_buffer;

    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          in_valid [3];
    logic          in_ready [3];
    logic          win_valid [3];
    logic          win_ready [3];
    logic          frame_done [3];
    logic signed [DW-1:0] in_data [3];
    logic signed [DW-1:0] a00 [3];
    logic signed [DW-1:0] a01 [3];
    logic signed [DW-1:0] a10 [3];
    logic signed [DW-1:0] a11 [3];

    int n_tests = 0;
    int n_fail  = 0;
    int fd_cnt [3];
    int pix_buf [72];
    bit rnd_en = 1'b0;

    typedef struct {
        int k;
        int a;
        int b;
        int c;
        int d;
    } win_t;
    win_t wq[$];

    typedef struct {
        int k;
        int base;
        int npix;
        int nwin;
        int e [16];
    } vec_t;
    vec_t vt [4];

    pool_window_buffer #(.DATA_WIDTH(DW), .IMG_WIDTH(4), .IMG_HEIGHT(4)) u_dut44 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .win_valid(win_valid[0]), .win_ready(win_ready[0]),
        .win_a00(a00[0]), .win_a01(a01[0]), .win_a10(a10[0]), .win_a11(a11[0]),
        .frame_done(frame_done[0]));

    pool_window_buffer #(.DATA_WIDTH(DW), .IMG_WIDTH(5), .IMG_HEIGHT(3)) u_dut53 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .win_valid(win_valid[1]), .win_ready(win_ready[1]),
        .win_a00(a00[1]), .win_a01(a01[1]), .win_a10(a10[1]), .win_a11(a11[1]),
        .frame_done(frame_done[1]));

    pool_window_buffer #(.DATA_WIDTH(DW), .IMG_WIDTH(6), .IMG_HEIGHT(4)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2]), .win_valid(win_valid[2]), .win_ready(win_ready[2]),
        .win_a00(a00[2]), .win_a01(a01[2]), .win_a10(a10[2]), .win_a11(a11[2]),
        .frame_done(frame_done[2]));

    // Window transfers and frame_done pulses are observed mid-cycle.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst_n && win_valid[k] && win_ready[k]) begin
                wq.push_back('{k, int'(a00[k]), int'(a01[k]), int'(a10[k]), int'(a11[k])});
            end
            if (rst_n && frame_done[k]) begin
                fd_cnt[k]++;
            end
        end
    end

    function automatic int rl(int v);
`ifdef POOL_WIN_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    task automatic chk(string nm, int got, int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic send_pix(int k, int v);
        bit ok = 1'b0;
        if (rnd_en && ($urandom_range(0, 1) == 1)) begin
            in_valid[k] = 1'b0;
            @(posedge clk);
            #1;
        end
        in_valid[k] = 1'b1;
        in_data[k]  = DW'(v);
        for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge clk);
            ok = in_ready[k];
            @(posedge clk);
            #1;
        end
        in_valid[k] = 1'b0;
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    task automatic send_frame(int k, int n);
        for (int i = 0; i < n; i++) begin
            send_pix(k, pix_buf[i]);
        end
        chk("frame_done_after_last", int'(frame_done[k]), 1);
    endtask

    task automatic drain(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_win(string nm, int k, int e0, int e1, int e2, int e3);
        win_t w;
        if (wq.size() == 0) begin
            chk({nm, "_missing"}, 0, 1);
        end else begin
            w = wq.pop_front();
            chk({nm, "_inst"}, w.k, k);
            chk({nm, "_a00"}, w.a, rl(e0));
            chk({nm, "_a01"}, w.b, rl(e1));
            chk({nm, "_a10"}, w.c, rl(e2));
            chk({nm, "_a11"}, w.d, rl(e3));
        end
    endtask

    initial begin
        int cnt;
        vt[0] = '{0, 100, 16, 4, '{100, 101, 104, 105, 102, 103, 106, 107,
                                   108, 109, 112, 113, 110, 111, 114, 115}};
        vt[1] = '{0, 0, 16, 4, '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15}};
        vt[2] = '{1, 0, 15, 2, '{0, 1, 5, 6, 2, 3, 7, 8, 0, 0, 0, 0, 0, 0, 0, 0}};
        vt[3] = '{0, -20, 16, 4, '{-20, -19, -16, -15, -18, -17, -14, -13,
                                   -12, -11, -8, -7, -10, -9, -6, -5}};
        for (int k = 0; k < 3; k++) begin
            in_valid[k]  = 1'b0;
            in_data[k]   = '0;
            win_ready[k] = 1'b1;
            fd_cnt[k]    = 0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready[0]), 1);
        chk("rst_win_valid", int'(win_valid[0]), 0);
        chk("rst_a00", int'(a00[0]), 0);
        chk("rst_frame_done", int'(frame_done[0]), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Mid-frame reset while a window is held
        win_ready[0] = 1'b0;
        for (int i = 0; i < 6; i++) send_pix(0, i);
        @(negedge clk);
        chk("prerst_win_valid", int'(win_valid[0]), 1);
        chk("prerst_a11", int'(a11[0]), 5);
        rst_n = 1'b0;
        #1;
        chk("midrst_win_valid", int'(win_valid[0]), 0);
        chk("midrst_in_ready", int'(in_ready[0]), 1);
        chk("midrst_a11", int'(a11[0]), 0);
        drain(2);
        @(negedge clk) rst_n = 1'b1;
        win_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        wq.delete();

        // Table-driven frames, full throughput
        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < vt[v].npix; i++) pix_buf[i] = vt[v].base + i;
            wq.delete();
            fd_cnt[vt[v].k] = 0;
            send_frame(vt[v].k, vt[v].npix);
            drain(4);
            chk($sformatf("vec%0d_count", v), wq.size(), vt[v].nwin);
            chk($sformatf("vec%0d_fd_pulses", v), fd_cnt[vt[v].k], 1);
            for (int w = 0; w < vt[v].nwin; w++) begin
                chk_win($sformatf("vec%0d_w%0d", v, w), vt[v].k, vt[v].e[4*w],
                        vt[v].e[4*w+1], vt[v].e[4*w+2], vt[v].e[4*w+3]);
            end
        end

        // Backpressure from the first window
        wq.delete();
        win_ready[0] = 1'b0;
        for (int i = 0; i < 16; i++) pix_buf[i] = i;
        fork
            send_frame(0, 16);
        join_none
        cnt = 0;
        while (!win_valid[0] && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        chk("bp_valid_seen", int'(win_valid[0]), 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_win_valid", int'(win_valid[0]), 1);
            chk("bp_in_ready", int'(in_ready[0]), 0);
            chk("bp_a00", int'(a00[0]), 0);
            chk("bp_a01", int'(a01[0]), 1);
            chk("bp_a10", int'(a10[0]), 4);
            chk("bp_a11", int'(a11[0]), 5);
        end
        @(posedge clk);
        #1;
        win_ready[0] = 1'b1;
        wait fork;
        drain(4);
        chk("bp_count", wq.size(), 4);
        chk_win("bp_w0", 0, 0, 1, 4, 5);
        chk_win("bp_w1", 0, 2, 3, 6, 7);
        chk_win("bp_w2", 0, 8, 9, 12, 13);
        chk_win("bp_w3", 0, 10, 11, 14, 15);

        // Signed extremes pass bit-exact
        wq.delete();
        for (int i = 0; i < 16; i++) pix_buf[i] = 0;
        pix_buf[0] = -3;
        pix_buf[1] = -7;
        pix_buf[4] = 2;
        pix_buf[5] = -128;
        send_frame(0, 16);
        drain(4);
        chk("signed_count", wq.size(), 4);
        chk_win("signed_w0", 0, -3, -7, 2, -128);

        // Random handshakes over three 6x4 frames
        wq.delete();
        fd_cnt[2] = 0;
        for (int i = 0; i < 72; i++) pix_buf[i] = int'($urandom_range(0, 255)) - 128;
        rnd_en = 1'b1;
        fork
            begin
                while (rnd_en) begin
                    @(posedge clk);
                    #1;
                    win_ready[2] = ($urandom_range(0, 1) == 1);
                end
                win_ready[2] = 1'b1;
            end
        join_none
        send_frame(2, 72);
        rnd_en = 1'b0;
        cnt = 0;
        while (wq.size() < 18 && cnt < 400) begin
            @(posedge clk);
            cnt++;
        end
        drain(4);
        chk("rnd_count", wq.size(), 18);
        chk("rnd_fd_pulses", fd_cnt[2], 3);
        for (int f = 0; f < 3; f++) begin
            for (int r = 0; r < 2; r++) begin
                for (int c = 0; c < 3; c++) begin
                    int p;
                    p = f * 24 + (2 * r) * 6 + 2 * c;
                    chk_win($sformatf("rnd_f%0d_r%0d_c%0d", f, r, c), 2, pix_buf[p],
                            pix_buf[p+1], pix_buf[p+6], pix_buf[p+7]);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
